// File: rtl/tmr_intc.sv
// tmr_intc: interrupt responder for the dual-unit 8-bit timer.
// It latches rising edges on the timer requests and presents one vectored IRQ with an ack/EOI handshake.
module tmr_intc #(
  parameter int NUM_SRC   = 12,
  parameter int VEC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC-1:0]   src_en,
  output logic                 irq,
  output logic [VEC_WIDTH-1:0] irq_vec,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic [NUM_SRC-1:0]   src_clr,
  output logic [NUM_SRC-1:0]   pending,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_e;

  state_e               state_q;
  logic [NUM_SRC-1:0]   req_q;
  logic [NUM_SRC-1:0]   pend_q;
  logic [NUM_SRC-1:0]   pend_d;
  logic [NUM_SRC-1:0]   clr_q;
  logic [NUM_SRC-1:0]   clr_d;
  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   elig;
  logic                 irq_q;
  logic                 busy_q;
  logic [VEC_WIDTH-1:0] vec_q;
  logic [VEC_WIDTH-1:0] win_idx;

  // Only enabled sources create edges; edges on masked sources are dropped rather than held.
  assign rise = src_req & ~req_q & src_en;
  assign elig = pend_q & src_en;

  always_comb begin
    clr_d = '0;
    if (state_q == ASSERT && irq_ack) begin
      clr_d = NUM_SRC'(1) << vec_q;
    end
  end

  // Any new edge wins over a same-cycle clear, so a re-trigger during ack is not lost.
  assign pend_d = (pend_q & ~clr_d) | rise;

  // Scanning from the top down leaves the lowest eligible index as the winner.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_idx = VEC_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q  <= '0;
      pend_q <= '0;
      clr_q  <= '0;
    end else begin
      req_q  <= src_req;
      pend_q <= pend_d;
      clr_q  <= clr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig != '0) begin
            vec_q   <= win_idx;
            irq_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq_q   <= 1'b0;
            state_q <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq     = irq_q;
  assign irq_vec = vec_q;
  assign src_clr = clr_q;
  assign pending = pend_q;
  assign busy    = busy_q;

endmodule

// File: doc/tmr_intc.md
Name: tmr_intc

Overview:
Interrupt responder for the dual-unit 8-bit timer. It consumes the twelve timer interrupt requests: CMIA0-3, CMIB0-3 and OVI0-3. It latches rising edges into a pending register, masks and prioritises them, and presents a single vectored request to the CPU with a request/acknowledge/end-of-interrupt handshake. On acknowledge it returns a one-cycle clear pulse to the originating timer flag.

Parameters:
NUM_SRC, 12, number of interrupt sources (fixed mapping below; other values unsupported).
VEC_WIDTH, 4, width of vector output; must satisfy 2^VEC_WIDTH >= NUM_SRC.

Ports:
clk  input  1  single system clock; all state on rising edge.
rst  input  1  asynchronous active-high reset.
src_req  input  NUM_SRC  level requests. Bits 0-3 are CMIA0-3, bits 4-7 are CMIB0-3, bits 8-11 are OVI0-3.
src_en  input  NUM_SRC  per-source enable mask (1 = enabled).
irq  output  1  interrupt request to CPU.
irq_vec  output  VEC_WIDTH  index of the source being presented.
irq_ack  input  1  CPU acknowledge pulse.
irq_eoi  input  1  CPU end-of-interrupt pulse.
src_clr  output  NUM_SRC  one-hot, one-cycle clear pulse back to the timer flag.
pending  output  NUM_SRC  pending register, for status readback.
busy  output  1  high in ASSERT or SERVICE.

Behaviour:
- Reset (asynchronous, immediate): pending=0, req_d=0, state=IDLE, irq=0, irq_vec=0, src_clr=0, busy=0.
- Edge detect:
  - req_d <= src_req every cycle.
  - rise[i] = src_req[i] & ~req_d[i] & src_en[i].
  - Edges on disabled sources are discarded, not deferred.
  - A level held high produces exactly one edge.
- Pending update:
  - pending[i] <= (pending[i] & ~clr_now[i]) | rise[i].
  - If set and clear coincide on the same bit, set wins: the bit stays 1.
- Eligibility:
  - elig = pending & src_en.
  - Fixed priority: the lowest index wins (CMIA0 highest, OVI3 lowest).
  - A pending bit whose enable is later dropped stays pending but is not eligible until re-enabled.
- FSM, states IDLE, ASSERT, SERVICE:
  - IDLE: if elig != 0, latch irq_vec = index of the highest-priority eligible bit and go to ASSERT. Otherwise stay.
  - ASSERT: irq=1 and irq_vec is held stable.
    - The request is committed: changes to src_en or new higher-priority edges do not alter irq_vec.
    - On irq_ack=1: clear pending[irq_vec], pulse src_clr[irq_vec] for exactly that cycle+1 (registered, one cycle wide), deassert irq next cycle, go to SERVICE.
  - SERVICE: irq=0 and busy=1. New edges still set pending. On irq_eoi=1, go to IDLE.
  - irq_eoi outside SERVICE and irq_ack outside ASSERT are ignored.
- Latency:
  - src_req rises and is sampled at edge N; pending is set after edge N; the FSM sees elig at N+1; irq=1 after edge N+1.
  - Minimum request-to-irq latency is 2 clk.
  - irq_eoi at edge M allows the next irq after edge M+1 (IDLE evaluates at M+1).
- Registered outputs: irq, irq_vec and src_clr are registered. pending and busy are direct register outputs.
- Reset mid-operation: reset in ASSERT or SERVICE returns to IDLE with all pending lost and no src_clr pulse emitted.
- Re-trigger: a new edge on the source currently in SERVICE sets pending again and is served after EOI.

Test Plan:
1. Reset, src_en=12'hFFF, pulse src_req[8] (OVI0) high for 3 cycles -> irq=1 two cycles after rise, irq_vec=8, single edge only (pending=12'h100).
2. Same-cycle rises on bits 5, 2, 11 -> vectors served in order 2, 5, 11. Each ack produces src_clr = 12'h004, then 12'h020, then 12'h800, each exactly one cycle. pending ends at 0.
3. src_en=12'hFFE, rise on bit 0 -> pending stays 0, irq stays 0. Then set src_en=12'hFFF with src_req[0] still high -> no irq (no new edge).
4. pending bit 3 set, clear src_en[3] before IDLE evaluation -> no irq, pending=12'h008 retained. Re-enable -> irq with irq_vec=3.
5. In ASSERT with vec=7, rise on bit 1 -> irq_vec remains 7. After ack+eoi, next irq_vec=1. Rise on bit 7 in the same cycle as its ack -> pending[7] stays 1 (set wins).
6. Assert rst in SERVICE with pending=12'h0F0 -> irq=0, pending=0, busy=0, src_clr=0 immediately. No further activity without new edges.
